uart_bfm_xcvr: RTL and testbench

- Clocked 8N1 UART transceiver used as the simulation-side serial partner of the SoC's UART pins.
- Transmitter sends bytes presented on a level start/busy handshake onto ser_tx, which drives the SoC RX pad.
- Receiver decodes frames arriving on ser_rx from the SoC TX pad and presents each byte with a one-cycle valid strobe.
- Both directions share one baud divider parameter and run fully independently.

---
 rtl/uart_bfm_xcvr.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_bfm_xcvr.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bfm_xcvr.sv
// uart_bfm_xcvr - 8N1 UART transceiver acting as the serial partner of the
// SoC UART pins. The transmitter and receiver share BAUD_DIV and run
// independently of each other.
//
// Ports:
//   clock        system clock, rising edge
//   resetb       asynchronous active-low reset
//   ser_rx       serial input, idle high (from SoC TX)
//   ser_tx       serial output, idle high (to SoC RX)
//   tx_start     level request to send tx_data
//   tx_data      byte to send, latched on the accept cycle
//   tx_busy      high while a frame is on ser_tx
//   tx_clear_req frame done but tx_start still held; host should drop it
//   rx_data      last received byte
//   rx_valid     one-cycle pulse, rx_data holds a good frame
//   rx_err       one-cycle pulse, stop bit was sampled low
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | line idle, waiting for an armed tx_start
//   TX_START | driving the start bit
//   TX_DATA  | driving data bits 0..7, LSB first
//   TX_STOP  | driving the stop bit
//   TX_HOLD  | frame done, tx_start still high, tx_clear_req asserted
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for a low level on the synchronized line
//   RX_START | counting to mid start bit to reject glitches
//   RX_DATA  | sampling 8 data bits at bit centres
//   RX_STOP  | sampling the stop bit
//   RX_WAIT  | framing error seen, waiting for the line to return high

module uart_bfm_xcvr #(
    parameter int unsigned BAUD_DIV = 4167
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       ser_rx,
    output logic       ser_tx,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_clear_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'((BAUD_DIV / 2) - 1);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_HOLD
    } tx_state_t;

    tx_state_t   tx_state, tx_state_nxt;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_idx;
    logic [7:0]  tx_shreg;
    logic        tx_armed;
    logic        tx_accept;
    logic        tx_bit_end;

    assign tx_bit_end = (tx_cnt == 16'd0);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) tx_state <= TX_IDLE;
        else         tx_state <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_accept    = 1'b0;
        ser_tx       = 1'b1;
        tx_busy      = 1'b0;
        tx_clear_req = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (tx_start && tx_armed) begin
                    tx_accept    = 1'b1;
                    tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                ser_tx  = 1'b0;
                tx_busy = 1'b1;
                if (tx_bit_end) tx_state_nxt = TX_DATA;
            end
            TX_DATA: begin
                ser_tx  = tx_shreg[0];
                tx_busy = 1'b1;
                if (tx_bit_end && (tx_idx == 3'd7)) tx_state_nxt = TX_STOP;
            end
            TX_STOP: begin
                tx_busy = 1'b1;
                if (tx_bit_end) tx_state_nxt = tx_start ? TX_HOLD : TX_IDLE;
            end
            TX_HOLD: begin
                // Combinational so the request drops the same cycle tx_start does.
                tx_clear_req = tx_start;
                if (!tx_start) tx_state_nxt = TX_IDLE;
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            tx_cnt   <= 16'd0;
            tx_idx   <= 3'd0;
            tx_shreg <= 8'd0;
            tx_armed <= 1'b1;
        end else begin
            // Re-arm only once tx_start has been seen low, so a held request
            // never produces a second frame.
            if (tx_accept)      tx_armed <= 1'b0;
            else if (!tx_start) tx_armed <= 1'b1;

            if (tx_accept) begin
                tx_shreg <= tx_data;
                tx_cnt   <= BIT_LAST;
                tx_idx   <= 3'd0;
            end else if (tx_state == TX_START || tx_state == TX_DATA ||
                         tx_state == TX_STOP) begin
                if (tx_bit_end) begin
                    tx_cnt <= BIT_LAST;
                    if (tx_state == TX_DATA) begin
                        tx_shreg <= {1'b0, tx_shreg[7:1]};
                        tx_idx   <= tx_idx + 3'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt - 16'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
    } rx_state_t;

    rx_state_t   rx_state, rx_state_nxt;
    logic        rx_sync1, rxs;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_shreg;
    logic        rx_bit_end;
    logic        rx_arm_half;
    logic        rx_sample;
    logic        rx_done_ok;
    logic        rx_done_bad;

    assign rx_bit_end = (rx_cnt == 16'd0);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rx_sync1 <= 1'b1;
            rxs      <= 1'b1;
            rx_state <= RX_IDLE;
        end else begin
            rx_sync1 <= ser_rx;
            rxs      <= rx_sync1;
            rx_state <= rx_state_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_arm_half  = 1'b0;
        rx_sample    = 1'b0;
        rx_done_ok   = 1'b0;
        rx_done_bad  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rxs) begin
                    rx_arm_half  = 1'b1;
                    rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (rx_bit_end) rx_state_nxt = rxs ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_sample = 1'b1;
                    if (rx_idx == 3'd7) rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    if (rxs) begin
                        rx_done_ok   = 1'b1;
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        rx_done_bad  = 1'b1;
                        rx_state_nxt = RX_WAIT;
                    end
                end
            end
            RX_WAIT: begin
                if (rxs) rx_state_nxt = RX_IDLE;
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rx_cnt   <= 16'd0;
            rx_idx   <= 3'd0;
            rx_shreg <= 8'd0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_valid <= rx_done_ok;
            rx_err   <= rx_done_bad;
            if (rx_done_ok || rx_done_bad) rx_data <= rx_shreg;

            if (rx_arm_half) begin
                rx_cnt <= HALF_LAST;
                rx_idx <= 3'd0;
            end else if (rx_state == RX_START || rx_state == RX_DATA ||
                         rx_state == RX_STOP) begin
                if (rx_bit_end) rx_cnt <= BIT_LAST;
                else            rx_cnt <= rx_cnt - 16'd1;
            end

            if (rx_sample) begin
                rx_shreg <= {rxs, rx_shreg[7:1]};
                rx_idx   <= rx_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_bfm_xcvr.sv
// tb_uart_bfm_xcvr - directed plus randomized bench for uart_bfm_xcvr at
// BAUD_DIV=16. Expected line waveforms and received bytes come from the
// frame rules (start 0, LSB-first data, stop 1, fixed bit time).

module tb_uart_bfm_xcvr;

    localparam int B = 16;

    logic       clock = 1'b0;
    logic       resetb = 1'b0;
    logic       ser_rx_drv = 1'b1;
    logic       loopback = 1'b0;
    logic       ser_rx;
    logic       ser_tx;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_busy;
    logic       tx_clear_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;

    int checks = 0;
    int fails  = 0;

    // {is_err, byte}
    logic [8:0] ev_q[$];
    logic [8:0] exp_q[$];

    assign ser_rx = loopback ? ser_tx : ser_rx_drv;

    uart_bfm_xcvr #(.BAUD_DIV(B)) dut (
        .clock        (clock),
        .resetb       (resetb),
        .ser_rx       (ser_rx),
        .ser_tx       (ser_tx),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .tx_clear_req (tx_clear_req),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_err       (rx_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (resetb) begin
            if (rx_valid) ev_q.push_back({1'b0, rx_data});
            if (rx_err)   ev_q.push_back({1'b1, rx_data});
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] want);
        checks++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic check_rx(input string tag);
        logic [8:0] a, e;
        check($sformatf("%s rx_events", tag), 16'(ev_q.size()), 16'(exp_q.size()));
        while (ev_q.size() > 0 && exp_q.size() > 0) begin
            a = ev_q.pop_front();
            e = exp_q.pop_front();
            check($sformatf("%s rx_event", tag), {7'd0, a}, {7'd0, e});
        end
        ev_q.delete();
        exp_q.delete();
    endtask

    // Sends one frame; drop_at < 0 keeps tx_start high through the frame,
    // otherwise tx_start is released drop_at cycles after accept.
    task automatic tx_frame(input logic [7:0] d, input int drop_at, input string tag);
        logic [9:0] bits;
        int busy_n;
        bits = {1'b1, d, 1'b0};
        @(negedge clock);
        tx_data  = d;
        tx_start = 1'b1;
        @(posedge clock); #1;
        check($sformatf("%s busy_rise", tag), 16'(tx_busy), 16'd1);
        busy_n = 0;
        for (int j = 0; j < 10 * B + 4; j++) begin
            if (tx_busy) busy_n++;
            if ((j % B) == (B / 2) && (j / B) < 10)
                check($sformatf("%s bit%0d", tag, j / B), 16'(ser_tx), 16'(bits[j / B]));
            if (j == 20) tx_data = ~d;
            if (j == drop_at) tx_start = 1'b0;
            @(posedge clock); #1;
        end
        check($sformatf("%s busy_len", tag), 16'(busy_n), 16'(10 * B));
        check($sformatf("%s busy_end", tag), 16'(tx_busy), 16'd0);
        check($sformatf("%s clear_req", tag), 16'(tx_clear_req), 16'(drop_at < 0));
        check($sformatf("%s idle_line", tag), 16'(ser_tx), 16'd1);
    endtask

    // Holds tx_start for a while (no retransmit), then releases it.
    task automatic hold_and_release(input string tag);
        int busy_n, req_n;
        busy_n = 0;
        req_n  = 0;
        for (int j = 0; j < 3 * B; j++) begin
            if (tx_busy) busy_n++;
            if (tx_clear_req) req_n++;
            @(posedge clock); #1;
        end
        check($sformatf("%s no_retx", tag), 16'(busy_n), 16'd0);
        check($sformatf("%s req_held", tag), 16'(req_n), 16'(3 * B));
        @(negedge clock);
        tx_start = 1'b0;
        #1;
        check($sformatf("%s req_drop", tag), 16'(tx_clear_req), 16'd0);
        @(posedge clock); #1;
        check($sformatf("%s req_low", tag), 16'(tx_clear_req), 16'd0);
    endtask

    task automatic rx_drive(input logic [7:0] d, input logic stop_bit, input int stop_len);
        @(negedge clock);
        ser_rx_drv = 1'b0;
        repeat (B) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            ser_rx_drv = d[i];
            repeat (B) @(negedge clock);
        end
        ser_rx_drv = stop_bit;
        repeat (stop_len) @(negedge clock);
        ser_rx_drv = 1'b1;
        repeat (2 * B) @(negedge clock);
    endtask

    initial begin
        logic [7:0] r;
        logic       bad;
        int         drop;

        // Reset
        repeat (3) @(negedge clock);
        resetb = 1'b1;
        #1;
        check("rst ser_tx", 16'(ser_tx), 16'd1);
        check("rst tx_busy", 16'(tx_busy), 16'd0);
        check("rst clear_req", 16'(tx_clear_req), 16'd0);
        check("rst rx_valid", 16'(rx_valid), 16'd0);
        check("rst rx_err", 16'(rx_err), 16'd0);
        check("rst rx_data", 16'(rx_data), 16'h00);
        repeat (2) @(posedge clock);

        // Held request, then deassert/reassert for the next byte
        tx_frame(8'h3D, -1, "tx3d");
        hold_and_release("tx3d");
        tx_frame(8'h0F, -1, "tx0f");
        hold_and_release("tx0f");

        // Loopback, two frames back to back
        loopback = 1'b1;
        exp_q.push_back({1'b0, 8'h3D});
        tx_frame(8'h3D, -1, "lb3d");
        @(negedge clock);
        tx_start = 1'b0;
        exp_q.push_back({1'b0, 8'hA5});
        tx_frame(8'hA5, 30, "lba5");
        repeat (2 * B) @(posedge clock);
        check_rx("loopback");
        loopback = 1'b0;

        // Framing error followed by a good frame
        rx_drive(8'h55, 1'b0, 40);
        exp_q.push_back({1'b1, 8'h55});
        rx_drive(8'h12, 1'b1, B);
        exp_q.push_back({1'b0, 8'h12});
        check_rx("rx_err_then_ok");
        check("rx hold 12", 16'(rx_data), 16'h12);

        // Short low glitch must be rejected
        @(negedge clock);
        ser_rx_drv = 1'b0;
        repeat (4) @(negedge clock);
        ser_rx_drv = 1'b1;
        repeat (3 * B) @(negedge clock);
        check_rx("glitch");
        check("glitch rx_data", 16'(rx_data), 16'h12);

        // Randomized receive frames, some with a low stop bit
        for (int k = 0; k < 5; k++) begin
            r   = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            rx_drive(r, !bad, bad ? $urandom_range(B, 3 * B) : B);
            exp_q.push_back({bad, r});
        end
        check_rx("rx_random");

        // Randomized transmit frames with random release points
        for (int k = 0; k < 3; k++) begin
            r    = 8'($urandom);
            drop = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 10 * B - 1));
            tx_frame(r, drop, $sformatf("txr%0d", k));
            if (drop < 0) hold_and_release($sformatf("txr%0d", k));
        end

        // Reset in the middle of a transmit frame
        @(negedge clock);
        tx_data  = 8'hC3;
        tx_start = 1'b1;
        repeat (50) @(posedge clock);
        #2;
        resetb = 1'b0;
        #1;
        check("midrst ser_tx", 16'(ser_tx), 16'd1);
        check("midrst tx_busy", 16'(tx_busy), 16'd0);
        check("midrst clear_req", 16'(tx_clear_req), 16'd0);
        check("midrst rx_data", 16'(rx_data), 16'h00);
        tx_start = 1'b0;
        @(negedge clock);
        resetb = 1'b1;
        r = 8'($urandom);
        tx_frame(r, 5, "after_rst");
        repeat (B) @(posedge clock);
        check_rx("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
